// File: rtl/framebuffer_stream_sink_if.sv
// Bundles the AXIS pixel stream and the memory write port of the framebuffer stream sink.
// The sink uses the slave view; the producer/memory side uses the master view.
interface framebuffer_stream_sink_if #(
  parameter int STREAM_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH   = 14,
  parameter int STROBES_PER_BEAT = 4
);
  // AXIS pixel stream
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic                        s_axis_tlast;
  logic [STREAM_WIDTH-1:0]     s_axis_tdata;

  // Memory write port
  logic                        memWrite;
  logic                        memReady;
  logic [MEM_ADDR_WIDTH-1:0]   memAddr;
  logic [STREAM_WIDTH-1:0]     memData;
  logic [STROBES_PER_BEAT-1:0] memMask;

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, memReady,
    input  s_axis_tready, memWrite, memAddr, memData, memMask
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, memReady,
    output s_axis_tready, memWrite, memAddr, memData, memMask
  );
endinterface

// File: rtl/framebuffer_stream_sink.sv
// AXIS slave that receives one framebuffer frame per apply and writes it beat-by-beat
// to a memory write port. A 2-entry skid buffer decouples the stream from write-port
// stalls so s_axis_tready can come straight from a flop. Framing is checked against
// the expected beat count; any mismatch sets a sticky tlastError.
module framebuffer_stream_sink #(
  parameter int FRAME_SIZE           = 128 * 128,
  parameter int STREAM_WIDTH         = 16,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int SUB_PIXEL_WIDTH      = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            apply,
  output logic                            applied,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0] writeMask,
  framebuffer_stream_sink_if.slave        bus,
  output logic                            frameDone,
  output logic                            tlastError
);
  localparam int PIXEL_WIDTH      = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH;
  localparam int PIXEL_PER_BEAT   = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int BEATS            = FRAME_SIZE / PIXEL_PER_BEAT;
  localparam int MEM_ADDR_WIDTH   = $clog2(FRAME_SIZE * PIXEL_WIDTH / 8) - 1 - $clog2(PIXEL_PER_BEAT);
  localparam int STROBES_PER_BEAT = STREAM_WIDTH / SUB_PIXEL_WIDTH;
  localparam int BEAT_CNT_WIDTH   = $clog2(BEATS + 1);
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                          stateReg, stateNext;
  logic [STREAM_WIDTH-1:0]         skid0Reg;      // head of the skid buffer, drives memData
  logic [STREAM_WIDTH-1:0]         skid1Reg;      // second entry, only valid when fill is 2
  logic [1:0]                      fillReg, fillNext;
  logic                            treadyReg, treadyNext;
  logic [BEAT_CNT_WIDTH-1:0]       beatCntReg;    // beats accepted in the current frame
  logic [MEM_ADDR_WIDTH-1:0]       memAddrReg;    // beats written in the current frame
  logic [NUMBER_OF_SUB_PIXELS-1:0] maskReg;
  logic                            tlastErrorReg;
  logic                            frameDoneReg;
  logic [STROBES_PER_BEAT-1:0]     maskBeat;
  logic                            memWrite;

  logic accept;      // beat handshake on the stream this cycle
  logic pop;         // write handshake on the memory port this cycle
  logic lastBeat;    // the beat on the stream would be the final one of a full frame
  logic frameEnd;    // accepted beat closes the frame, normally or by truncation
  logic finalWrite;  // last buffered beat leaves while draining
  logic armFrame;    // apply taken in IDLE

  assign accept     = bus.s_axis_tvalid && treadyReg;
  assign pop        = memWrite && bus.memReady;
  assign lastBeat   = (beatCntReg == LAST_BEAT);
  assign frameEnd   = accept && (bus.s_axis_tlast || lastBeat);
  assign finalWrite = (stateReg == DRAIN) && pop && (fillReg == 2'd1);
  assign armFrame   = (stateReg == IDLE) && apply;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic: arm on apply, stop receiving on frame end, return once drained.
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:    if (apply)      stateNext = RECV;
      RECV:    if (frameEnd)   stateNext = DRAIN;
      DRAIN:   if (finalWrite) stateNext = IDLE;
      default:                 stateNext = IDLE;
    endcase
  end

  // FSM outputs: idle indication and a pending write whenever the skid buffer holds data.
  always_comb begin
    applied  = (stateReg == IDLE);
    memWrite = (fillReg != 2'd0);
  end

  // Skid occupancy lookahead; ready is registered from the occupancy after this cycle.
  always_comb begin
    fillNext = fillReg;
    case ({accept, pop})
      2'b10:   fillNext = fillReg + 2'd1;
      2'b01:   fillNext = fillReg - 2'd1;
      default: fillNext = fillReg;
    endcase
    treadyNext = (stateNext == RECV) && (fillNext != 2'd2);
  end

  // Two-entry FIFO: head only advances on a write handshake so memData holds while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid0Reg <= '0;
      skid1Reg <= '0;
      fillReg  <= 2'd0;
    end else begin
      fillReg <= fillNext;
      if (accept && ((fillReg == 2'd0) || (pop && fillReg == 2'd1))) begin
        skid0Reg <= bus.s_axis_tdata;
      end else if (pop) begin
        skid0Reg <= skid1Reg;
      end
      if (accept && ((fillReg == 2'd1 && !pop) || fillReg == 2'd2)) begin
        skid1Reg <= bus.s_axis_tdata;
      end
    end
  end

  // Frame bookkeeping: mask latch, beat/address counters, framing error and done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      treadyReg     <= 1'b0;
      beatCntReg    <= '0;
      memAddrReg    <= '0;
      maskReg       <= '0;
      tlastErrorReg <= 1'b0;
      frameDoneReg  <= 1'b0;
    end else begin
      treadyReg    <= treadyNext;
      frameDoneReg <= finalWrite;
      if (armFrame) begin
        maskReg       <= writeMask;
        tlastErrorReg <= 1'b0;
        beatCntReg    <= '0;
        memAddrReg    <= '0;
      end else begin
        if (accept) begin
          beatCntReg <= beatCntReg + BEAT_CNT_WIDTH'(1);
          // Early tlast truncates the frame; a missing tlast on the final beat ends it anyway.
          if (bus.s_axis_tlast != lastBeat) begin
            tlastErrorReg <= 1'b1;
          end
        end
        if (pop) begin
          memAddrReg <= memAddrReg + MEM_ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Replicate the channel mask once per pixel packed in a beat.
  genvar gi;
  for (gi = 0; gi < PIXEL_PER_BEAT; gi++) begin : gMaskRep
    assign maskBeat[gi*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = maskReg;
  end

  assign bus.s_axis_tready = treadyReg;
  assign bus.memWrite      = memWrite;
  assign bus.memAddr       = memAddrReg;
  assign bus.memData       = skid0Reg;
  assign bus.memMask       = maskBeat;
  assign frameDone         = frameDoneReg;
  assign tlastError        = tlastErrorReg;
endmodule

// File: tb/tb_framebuffer_stream_sink.sv
// Scoreboard bench for framebuffer_stream_sink: the stream driver pushes the expected
// memory write for every accepted beat, and a monitor pops and compares on every write
// handshake. Prints one line per frame.
module tb_framebuffer_stream_sink;
  localparam int BEATS = 16384;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       apply = 1'b0;
  logic       applied;
  logic [3:0] writeMask = 4'h0;
  logic       frameDone;
  logic       tlastError;

  framebuffer_stream_sink_if bus ();

  framebuffer_stream_sink dut (
    .clk        (clk),
    .resetn     (resetn),
    .apply      (apply),
    .applied    (applied),
    .writeMask  (writeMask),
    .bus        (bus),
    .frameDone  (frameDone),
    .tlastError (tlastError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         writesSeen = 0;
  int         doneCount = 0;
  int         expDone = 0;
  logic [3:0] expMask = 4'h0;
  bit         randReady = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] pattern(int i, int seed);
    return 16'((i * 37 + seed) ^ 32'h5A5A);
  endfunction

  // Memory-side ready: always ready, or a coin toss per cycle.
  initial begin
    bus.memReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.memReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on writes, hold stability under stall, ready vs occupancy.
  initial begin
    bit          holdValid = 1'b0;
    logic [13:0] holdAddr;
    logic [15:0] holdData;
    logic [3:0]  holdMask;
    int          monAcc = 0;
    int          monWr = 0;
    bit          lastSeen = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        holdValid = 1'b0;
        monAcc = 0;
        monWr = 0;
        lastSeen = 1'b0;
      end else begin
        if (applied) begin
          check("idle_tready", bus.s_axis_tready, 0);
          check("idle_memWrite", bus.memWrite, 0);
          monAcc = 0;
          monWr = 0;
          lastSeen = 1'b0;
        end else if (!lastSeen) begin
          check("recv_tready_vs_occupancy", bus.s_axis_tready, ((monAcc - monWr) < 2));
        end
        if (holdValid) begin
          check("stall_memWrite_held", bus.memWrite, 1);
          check("stall_memAddr_stable", bus.memAddr, holdAddr);
          check("stall_memData_stable", bus.memData, holdData);
          check("stall_memMask_stable", bus.memMask, holdMask);
        end
        holdValid = bus.memWrite && !bus.memReady;
        holdAddr = bus.memAddr;
        holdData = bus.memData;
        holdMask = bus.memMask;
        if (bus.memWrite && bus.memReady) begin
          writesSeen++;
          monWr++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", bus.memAddr, bus.memData);
          end else begin
            e = expQ.pop_front();
            check("write_addr", bus.memAddr, e.addr);
            check("write_data", bus.memData, e.data);
            check("write_mask", bus.memMask, e.mask);
          end
        end
        if (bus.s_axis_tvalid && bus.s_axis_tready) begin
          monAcc++;
          if (bus.s_axis_tlast || monAcc == BEATS) lastSeen = 1'b1;
        end
        if (frameDone) doneCount++;
      end
    end
  end

  task automatic doApply(logic [3:0] mask);
    writeMask = mask;
    expMask = mask;
    writesSeen = 0;
    apply = 1'b1;
    @(posedge clk);
    #1;
    apply = 1'b0;
    check("apply_clears_tlastError", tlastError, 0);
    check("apply_applied_low", applied, 0);
    check("apply_tready_high", bus.s_axis_tready, 1);
  endtask

  task automatic sendFrame(int nBeats, int tlastAt, bit randGap, int seed, output bit ok);
    int waitCyc;
    ok = 1'b1;
    for (int i = 0; i < nBeats; i++) begin
      waitCyc = 0;
      if (randGap) begin
        while ($urandom_range(0, 1) == 0) begin
          bus.s_axis_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata = pattern(i, seed);
      bus.s_axis_tlast = (i == tlastAt);
      forever begin
        @(negedge clk);
        if (bus.s_axis_tready) break;
        waitCyc++;
        if (waitCyc > 200) break;
      end
      if (!bus.s_axis_tready) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted in 200 cycles, required acceptance", i);
        bus.s_axis_tvalid = 1'b0;
        ok = 1'b0;
        return;
      end
      expQ.push_back({14'(i), pattern(i, seed), expMask});
      @(posedge clk);
      #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic waitFrameEnd(string name, int expWrites, bit expErr);
    int cyc = 0;
    @(negedge clk);
    while (!applied && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!applied) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: applied=0 after 500 cycles, required 1", name);
    end
    @(posedge clk);
    #1;
    expDone++;
    check({name, "_writes"}, writesSeen, expWrites);
    check({name, "_queue_empty"}, expQ.size(), 0);
    check({name, "_frameDone_pulses"}, doneCount, expDone);
    check({name, "_tlastError"}, tlastError, expErr);
    check({name, "_applied"}, applied, 1);
    $display("frame %s: %0d writes, tlastError=%0b, frameDone pulses=%0d", name, writesSeen, tlastError, doneCount);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int readyHigh;
    int memwHigh;
    int doneBefore;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.s_axis_tdata = 16'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_applied", applied, 1);
    check("reset_tready", bus.s_axis_tready, 0);
    check("reset_memWrite", bus.memWrite, 0);
    check("reset_frameDone", frameDone, 0);
    check("reset_tlastError", tlastError, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1: full frame, tlast on the last beat, memory always ready
    doApply(4'hF);
    sendFrame(BEATS, BEATS - 1, 1'b0, 1, ok);
    waitFrameEnd("T1_full", BEATS, 1'b0);

    // T4: stream valid while idle, no apply
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = 16'hBEEF;
    readyHigh = 0;
    memwHigh = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.s_axis_tready) readyHigh++;
      if (bus.memWrite) memwHigh++;
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    check("T4_tready_cycles", readyHigh, 0);
    check("T4_memWrite_cycles", memwHigh, 0);
    check("T4_applied", applied, 1);
    $display("frame T4_idle: tready cycles=%0d, memWrite cycles=%0d", readyHigh, memwHigh);

    // T2: tlast on beat 99 truncates the frame
    doApply(4'hF);
    sendFrame(100, 99, 1'b0, 2, ok);
    waitFrameEnd("T2_truncated", 100, 1'b1);

    // T3: random stream gaps and random memory backpressure; apply clears the T2 error
    randReady = 1'b1;
    doApply(4'b1100);
    sendFrame(300, 299, 1'b1, 3, ok);
    waitFrameEnd("T3_random", 300, 1'b1);
    randReady = 1'b0;

    // T5: mask latched on apply; mid-frame mask change and apply are ignored
    doApply(4'b0101);
    fork
      sendFrame(50, 49, 1'b0, 4, ok);
      begin
        repeat (20) @(posedge clk);
        #1;
        writeMask = 4'b1010;
        apply = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
      end
    join
    waitFrameEnd("T5_mask", 50, 1'b1);

    // T6: reset after 10 accepted beats, then a fresh frame from address 0
    doApply(4'b0011);
    sendFrame(10, -1, 1'b0, 5, ok);
    doneBefore = doneCount;
    resetn = 1'b0;
    #1;
    check("T6_reset_applied", applied, 1);
    check("T6_reset_tready", bus.s_axis_tready, 0);
    check("T6_reset_memWrite", bus.memWrite, 0);
    check("T6_reset_frameDone", frameDone, 0);
    check("T6_reset_tlastError", tlastError, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("T6_no_frameDone_on_reset", doneCount, doneBefore);
    $display("frame T6_aborted: reset after 10 beats, frameDone pulses=%0d", doneCount);
    doApply(4'b0011);
    sendFrame(5, 4, 1'b0, 6, ok);
    waitFrameEnd("T6_restart", 5, 1'b1);

    // T7: full-length frame without tlast ends at the last beat with an error
    doApply(4'hF);
    sendFrame(BEATS, -1, 1'b0, 7, ok);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = 16'hDEAD;
    waitFrameEnd("T7_no_tlast", BEATS, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    check("T7_no_extra_writes", writesSeen, BEATS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
